// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//
// Multi-digit BCD down-counter. It is preset from load_val, then decrements
// by one unit on each tick while running. Each digit borrows from the digit
// above it. When the count expires it raises a one-cycle done pulse.
//
// Parameters
//   DIGITS    number of BCD digits (1..4). Digit 0 is the least significant
//             digit and sits in bits [3:0].
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   load      one-cycle request to preset count and reload from load_val
//   load_val  BCD preset value (4*DIGITS bits)
//   start     begin or resume counting (only from IDLE with count != 0)
//   stop      pause counting; the count is held
//   tick      count-enable strobe; one decrement per high cycle in RUN
//   count     current BCD value (registered)
//   running   high while in the RUN state (registered)
//   zero      combinational; high when count == 0
//   done      one-cycle pulse on expiry (registered)
//   load_err  one-cycle pulse after a load whose value holds a non-BCD
//             digit (registered)
//
// Per-cycle priority: load > stop > start > tick.
// Any load, whether or not it is valid, blocks stop, start and tick in that
// cycle.
//
// Optional feature macro: BCD_COUNTDOWN_AUTO_RELOAD_EN
//   When defined, expiry reloads count from the last valid preset and stays
//   in RUN, so the period is exactly `reload` ticks. A zero reload value
//   falls back to the one-shot behaviour.
//   When undefined, expiry clears count, returns to IDLE and drops running.
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   count_reg, count_next;
  logic [W-1:0]   reload_reg, reload_next;
  logic           done_reg, done_next;
  logic           load_err_reg, load_err_next;

  // Decrement datapath and preset validation, one slice per digit.
  logic [DIGITS-1:0] digit_ok;   // load_val digit is a legal BCD digit
  logic [DIGITS-1:0] borrow;     // borrow into this digit
  logic [W-1:0]      count_dec;  // count_reg minus one, in BCD

  logic load_ok;
  logic count_is_zero;
  logic count_is_one;
  logic reload_avail;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);

      // Digit 0 always decrements. A higher digit decrements only when
      // every digit below it is 0, which is when all of them wrap to 9.
      if (gi == 0) begin : g_lsd
        assign borrow[gi] = 1'b1;
      end else begin : g_upper
        assign borrow[gi] = borrow[gi-1] & (count_reg[4*(gi-1) +: 4] == 4'd0);
      end

      assign count_dec[4*gi +: 4] =
          !borrow[gi]                     ? count_reg[4*gi +: 4] :
          (count_reg[4*gi +: 4] == 4'd0)  ? 4'd9 :
                                            count_reg[4*gi +: 4] - 4'd1;
    end
  endgenerate

  assign load_ok       = &digit_ok;
  assign count_is_zero = (count_reg == '0);
  assign count_is_one  = (count_reg == W'(1));

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  // Auto-reload applies only when a non-zero period has been preset.
  assign reload_avail = (reload_reg != '0);
`else
  assign reload_avail = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    reload_next   = reload_reg;
    done_next     = 1'b0;
    load_err_next = 1'b0;

    if (load) begin
      // A bad preset leaves everything untouched except the error pulse.
      if (load_ok) begin
        count_next  = load_val;
        reload_next = load_val;
        state_next  = IDLE;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (stop) begin
      if (state_reg == RUN) begin
        state_next = IDLE;
      end
    end else if (start) begin
      if ((state_reg == IDLE) && !count_is_zero) begin
        state_next = RUN;
      end
    end else if (tick && (state_reg == RUN)) begin
      if (count_is_one) begin
        // Expiry: done pulses whether the timer reloads or finishes.
        done_next = 1'b1;
        if (reload_avail) begin
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = IDLE;
        end
      end else begin
        count_next = count_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      reload_reg   <= '0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      reload_reg   <= reload_next;
      done_reg     <= done_next;
      load_err_reg <= load_err_next;
    end
  end

  assign count    = count_reg;
  assign running  = (state_reg == RUN);
  assign zero     = count_is_zero;
  assign done     = done_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown_timer
//
// Self-checking bench for bcd_countdown_timer with DIGITS = 2. The reference
// model holds the count as a plain integer and applies the timer's rules with
// decimal arithmetic. It converts that integer to BCD only when comparing.
// Directed sequences are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_bcd_countdown_timer;

  localparam int D = 2;
  localparam int W = 4 * D;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         tick;
  logic [W-1:0] count;
  logic         running;
  logic         zero;
  logic         done;
  logic         load_err;

  int pass_count  = 0;
  int check_count = 0;

  // Reference model state.
  int m_cnt;
  int m_reload;
  bit m_run;
  bit m_done;
  bit m_err;

  bcd_countdown_timer #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .count    (count),
    .running  (running),
    .zero     (zero),
    .done     (done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed,
               expected, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_valid(input logic [W-1:0] b);
    for (int i = 0; i < D; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    m_reload = 0;
    m_run    = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
  endtask

  // Apply one clock's worth of the timer rules to the model.
  task automatic model_step(input logic l, input logic [W-1:0] lv,
                            input logic sa, input logic so, input logic ti);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (l) begin
      if (bcd_valid(lv)) begin
        m_cnt    = from_bcd(lv);
        m_reload = m_cnt;
        m_run    = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (so) begin
      m_run = 1'b0;
    end else if (sa) begin
      if (m_cnt != 0) m_run = 1'b1;
    end else if (ti && m_run) begin
      if (m_cnt == 1) begin
        m_done = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        if (m_reload != 0) begin
          m_cnt = m_reload;
        end else begin
          m_cnt = 0;
          m_run = 1'b0;
        end
`else
        m_cnt = 0;
        m_run = 1'b0;
`endif
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic compare_all();
    check("count",    32'(count),    32'(to_bcd(m_cnt)));
    check("running",  32'(running),  32'(m_run));
    check("zero",     32'(zero),     32'(m_cnt == 0));
    check("done",     32'(done),     32'(m_done));
    check("load_err", 32'(load_err), 32'(m_err));
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  // The trace line is printed before the comparisons so that any FAIL line
  // follows the transaction that caused it.
  task automatic step(input logic l, input logic [W-1:0] lv, input logic sa,
                      input logic so, input logic ti);
    @(negedge clk);
    load = l; load_val = lv; start = sa; stop = so; tick = ti;
    @(posedge clk);
    model_step(l, lv, sa, so, ti);
    #1;
    $display("t=%0t load=%0b lv=%02h start=%0b stop=%0b tick=%0b -> count=%02h run=%0b zero=%0b done=%0b err=%0b",
             $time, l, lv, sa, so, ti, count, running, zero, done, load_err);
    compare_all();
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  logic [W-1:0] rv;
  int r;

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = '0;
    start = 1'b0; stop = 1'b0; tick = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",    32'(count),    32'h0);
    check("rst_running",  32'(running),  32'h0);
    check("rst_zero",     32'(zero),     32'h1);
    check("rst_done",     32'(done),     32'h0);
    check("rst_load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 25, start, 25 ticks: full decade sweep to expiry.
    step(1, 8'h25, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Non-BCD preset: error pulse, and count and state stay unchanged.
    step(1, 8'h3A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Borrow path, stop+tick, resume.
    step(1, 8'h10, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Short period: exercises auto-reload when enabled.
    step(1, 8'h03, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 0, 0, 1);

    // Asynchronous reset mid-count.
    step(1, 8'h05, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    $display("t=%0t async reset asserted -> count=%02h run=%0b", $time,
             count, running);
    check("async_rst_count",   32'(count),   32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);

    // Load coincident with expiry: the load wins.
    step(1, 8'h01, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h07, 0, 0, 1);

    // Boundary presets: maximum value, then zero (start is ignored).
    step(1, 8'h99, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Randomized run.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) rv = 8'($urandom);
      else rv = to_bcd(int'($urandom_range(0, 20)));
      step(r < 6, rv, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 70);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Watchdog against a stalled simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
